// File: rtl/conv_window_feeder_pkg.sv
// Shared constants, window-count derivation and FSM encoding for the conv window feeder.
package conv_window_feeder_pkg;

  localparam int DATA_W   = 4;
  localparam int IMG_LEN  = 7;
  localparam int K        = 3;
  localparam int READ_LEN = 7;

  // LoadAddr width; buffers are sized to the full address space so any
  // index is in range, and only entries below IMG_LEN / K are ever written
  localparam int ADDR_W = 4;
  localparam int BUF_D  = 1 << ADDR_W;

  // number of filter placements over the image (valid positions only)
  function automatic int calc_nw(input int img_len, input int k);
    return img_len - k + 1;
  endfunction

  localparam int NW = calc_nw(IMG_LEN, K);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    READ   = 2'd3
  } state_t;

endpackage

// File: rtl/window_index_gen.sv
// Tap / window counters for the convolution stream; the pair points at the
// sample to be emitted on the next step.
module window_index_gen #(
  parameter int K  = 3,
  parameter int NW = 5
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     clear,
  input  logic                                     step,
  output logic [conv_window_feeder_pkg::ADDR_W-1:0] img_idx,
  output logic [conv_window_feeder_pkg::ADDR_W-1:0] tap_idx,
  output logic                                     last
);
  import conv_window_feeder_pkg::*;

  localparam logic [ADDR_W-1:0] T_MAX = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] W_MAX = ADDR_W'(NW - 1);

  logic [ADDR_W-1:0] t_q, w_q;

  // tap counter wraps every K steps; window counter moves on each wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q <= '0;
      w_q <= '0;
    end else if (clear) begin
      t_q <= '0;
      w_q <= '0;
    end else if (step) begin
      if (t_q == T_MAX) begin
        t_q <= '0;
        w_q <= (w_q == W_MAX) ? '0 : w_q + 1'b1;
      end else begin
        t_q <= t_q + 1'b1;
      end
    end
  end

  assign img_idx = w_q + t_q;
  assign tap_idx = t_q;
  assign last    = (t_q == T_MAX) && (w_q == W_MAX);

endmodule

// File: rtl/conv_window_feeder.sv
// Streams image/filter sample pairs for every valid filter placement to a
// conv layer, then flushes one cycle and holds ReadEn for the result read.
module conv_window_feeder #(
  parameter int DATA_W   = conv_window_feeder_pkg::DATA_W,
  parameter int IMG_LEN  = conv_window_feeder_pkg::IMG_LEN,
  parameter int K        = conv_window_feeder_pkg::K,
  parameter int READ_LEN = conv_window_feeder_pkg::READ_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LoadImg,
  input  logic              LoadFlt,
  input  logic [3:0]        LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  input  logic              Go,
  output logic              Start,
  output logic [DATA_W-1:0] Image,
  output logic [DATA_W-1:0] Filter,
  output logic              ReadEn,
  output logic              Busy,
  output logic              Done
);
  import conv_window_feeder_pkg::*;

  localparam int NWIN = calc_nw(IMG_LEN, K);
  localparam int RW   = $clog2(READ_LEN + 1);

  logic [DATA_W-1:0] img_buf [BUF_D];
  logic [DATA_W-1:0] flt_buf [BUF_D];

  state_t          state_q, state_d;
  logic            tail_q, tail_d;   // final sample already on the outputs
  logic [RW-1:0]   rcnt_q, rcnt_d;   // READ cycles issued so far

  logic              start_d, readen_d, done_d, busy_d;
  logic [DATA_W-1:0] image_d, filter_d;

  logic              step, clear, last;
  logic [ADDR_W-1:0] img_idx, tap_idx;

  window_index_gen #(.K(K), .NW(NWIN)) u_idx (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .step    (step),
    .img_idx (img_idx),
    .tap_idx (tap_idx),
    .last    (last)
  );

  // sample buffers: writable only while idle and only at in-range indices
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_D; i++) begin
        img_buf[i] <= '0;
        flt_buf[i] <= '0;
      end
    end else if (state_q == IDLE) begin
      if (LoadImg && (LoadAddr < ADDR_W'(IMG_LEN))) img_buf[LoadAddr] <= LoadData;
      if (LoadFlt && (LoadAddr < ADDR_W'(K)))       flt_buf[LoadAddr] <= LoadData;
    end
  end

  // next state and next registered output values
  always_comb begin
    state_d  = state_q;
    tail_d   = tail_q;
    rcnt_d   = rcnt_q;
    start_d  = 1'b0;
    image_d  = '0;
    filter_d = '0;
    readen_d = 1'b0;
    done_d   = 1'b0;
    step     = 1'b0;
    clear    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Go) begin
          state_d  = STREAM;
          step     = 1'b1;
          tail_d   = last;
          start_d  = 1'b1;
          image_d  = img_buf[img_idx];
          filter_d = flt_buf[tap_idx];
        end
      end
      STREAM: begin
        if (tail_q) begin
          state_d = FLUSH;
          tail_d  = 1'b0;
          clear   = 1'b1;
        end else begin
          step     = 1'b1;
          tail_d   = last;
          start_d  = 1'b1;
          image_d  = img_buf[img_idx];
          filter_d = flt_buf[tap_idx];
        end
      end
      FLUSH: begin
        state_d  = READ;
        rcnt_d   = RW'(1);
        readen_d = 1'b1;
        done_d   = (READ_LEN == 1);
      end
      READ: begin
        if (rcnt_q == RW'(READ_LEN)) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else begin
          rcnt_d   = rcnt_q + 1'b1;
          readen_d = 1'b1;
          done_d   = ((rcnt_q + 1'b1) == RW'(READ_LEN));
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tail_q  <= 1'b0;
      rcnt_q  <= '0;
      Start   <= 1'b0;
      Image   <= '0;
      Filter  <= '0;
      ReadEn  <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      rcnt_q  <= rcnt_d;
      Start   <= start_d;
      Image   <= image_d;
      Filter  <= filter_d;
      ReadEn  <= readen_d;
      Busy    <= busy_d;
      Done    <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench: default 7/3 instance plus a K == IMG_LEN == 3 instance.
module tb_conv_window_feeder;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst0, li0, lf0, go0;
  logic [3:0]    la0;
  logic [DW-1:0] ld0, im0, fl0;
  logic          st0, re0, by0, dn0;

  logic          rst1, li1, lf1, go1;
  logic [3:0]    la1;
  logic [DW-1:0] ld1, im1, fl1;
  logic          st1, re1, by1, dn1;

  int checks = 0;
  int errors = 0;

  int exp_img [15] = '{1, 2, 3, 2, 3, 4, 3, 4, 5, 4, 5, 6, 5, 6, 7};
  int exp_k3  [3]  = '{4, 5, 6};

  conv_window_feeder u0 (
    .clk(clk), .reset(rst0), .LoadImg(li0), .LoadFlt(lf0), .LoadAddr(la0),
    .LoadData(ld0), .Go(go0), .Start(st0), .Image(im0), .Filter(fl0),
    .ReadEn(re0), .Busy(by0), .Done(dn0)
  );

  conv_window_feeder #(.IMG_LEN(3), .K(3)) u1 (
    .clk(clk), .reset(rst1), .LoadImg(li1), .LoadFlt(lf1), .LoadAddr(la1),
    .LoadData(ld1), .Go(go1), .Start(st1), .Image(im1), .Filter(fl1),
    .ReadEn(re1), .Busy(by1), .Done(dn1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic img, input logic flt, input int a, input int d);
    li0 = img; lf0 = flt; la0 = 4'(a); ld0 = DW'(d);
    tick();
    li0 = 1'b0; lf0 = 1'b0;
  endtask

  task automatic load1(input logic img, input logic flt, input int a, input int d);
    li1 = img; lf1 = flt; la1 = 4'(a); ld1 = DW'(d);
    tick();
    li1 = 1'b0; lf1 = 1'b0;
  endtask

  task automatic fill0();
    load0(1'b1, 1'b1, 0, 1);  // img[0] and flt[0] written together
    for (int i = 1; i < 7; i++) load0(1'b1, 1'b0, i, i + 1);
    load0(1'b0, 1'b1, 1, 2);
    load0(1'b0, 1'b1, 2, 3);
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (2) tick();
    checks++;
    if ({st0, re0, by0, dn0, im0, fl0} !== '0) begin
      errors++;
      $display("FAIL reset_u0 got st=%b re=%b busy=%b done=%b img=%0d flt=%0d expected all 0", st0, re0, by0, dn0, im0, fl0);
    end
    checks++;
    if ({st1, re1, by1, dn1, im1, fl1} !== '0) begin
      errors++;
      $display("FAIL reset_u1 got st=%b re=%b busy=%b done=%b img=%0d flt=%0d expected all 0", st1, re1, by1, dn1, im1, fl1);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    tick();
    checks++;
    if (by0 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", by0); end
  endtask

  task automatic test_stream();
    fill0();
    go0 = 1'b1; tick(); go0 = 1'b0;
    for (int n = 0; n < 15; n++) begin
      checks++;
      if (st0 !== 1'b1 || im0 !== DW'(exp_img[n]) || fl0 !== DW'(n % 3 + 1) || by0 !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d] got st=%b img=%0d flt=%0d busy=%b expected 1 %0d %0d 1", n, st0, im0, fl0, by0, exp_img[n], n % 3 + 1);
      end
      tick();
    end
    checks++;
    if ({st0, im0, fl0, re0, dn0} !== '0 || by0 !== 1'b1) begin
      errors++;
      $display("FAIL flush got st=%b img=%0d flt=%0d re=%b done=%b busy=%b expected 0 0 0 0 0 1", st0, im0, fl0, re0, dn0, by0);
    end
    for (int r = 1; r <= 7; r++) begin
      tick();
      checks++;
      if (re0 !== 1'b1 || dn0 !== (r == 7) || st0 !== 1'b0 || by0 !== 1'b1) begin
        errors++;
        $display("FAIL read[%0d] got re=%b done=%b st=%b busy=%b expected 1 %b 0 1", r, re0, dn0, st0, by0, r == 7);
      end
    end
    tick();
    checks++;
    if (by0 !== 1'b0 || re0 !== 1'b0 || dn0 !== 1'b0) begin
      errors++;
      $display("FAIL after_read got busy=%b re=%b done=%b expected 0 0 0", by0, re0, dn0);
    end
  endtask

  task automatic test_ignore_during_stream();
    go0 = 1'b1; tick(); go0 = 1'b0;
    for (int n = 0; n < 15; n++) begin
      checks++;
      if (st0 !== 1'b1 || im0 !== DW'(exp_img[n]) || fl0 !== DW'(n % 3 + 1)) begin
        errors++;
        $display("FAIL ignore_stream[%0d] got st=%b img=%0d flt=%0d expected 1 %0d %0d", n, st0, im0, fl0, exp_img[n], n % 3 + 1);
      end
      if (n == 2) begin go0 = 1'b1; li0 = 1'b1; la0 = 4'd0; ld0 = DW'(9); end
      else        begin go0 = 1'b0; li0 = 1'b0; end
      tick();
    end
    repeat (8) tick();
    checks++;
    if (by0 !== 1'b0) begin errors++; $display("FAIL ignore_end_busy got %b expected 0", by0); end
    go0 = 1'b1; tick(); go0 = 1'b0;
    checks++;
    if (st0 !== 1'b1 || im0 !== DW'(1) || fl0 !== DW'(1)) begin
      errors++;
      $display("FAIL replay_first got st=%b img=%0d flt=%0d expected 1 1 1", st0, im0, fl0);
    end
    for (int c = 0; c < 40 && by0 === 1'b1; c++) tick();
    checks++;
    if (by0 !== 1'b0) begin errors++; $display("FAIL replay_timeout busy=%b expected 0", by0); end
  endtask

  task automatic test_back_to_back();
    go0 = 1'b1; tick(); go0 = 1'b0;
    repeat (15) tick();
    repeat (7) tick();
    checks++;
    if (dn0 !== 1'b1 || re0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got done=%b re=%b expected 1 1", dn0, re0);
    end
    go0 = 1'b1; tick(); go0 = 1'b0;
    checks++;
    if (by0 !== 1'b0 || st0 !== 1'b0) begin
      errors++;
      $display("FAIL go_on_return got busy=%b st=%b expected 0 0", by0, st0);
    end
    tick();
    checks++;
    if (by0 !== 1'b0 || st0 !== 1'b0) begin
      errors++;
      $display("FAIL go_on_return_next got busy=%b st=%b expected 0 0", by0, st0);
    end
    go0 = 1'b1; tick(); go0 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (st0 !== 1'b1 || im0 !== DW'(exp_img[n]) || fl0 !== DW'(n + 1)) begin
        errors++;
        $display("FAIL b2b_stream[%0d] got st=%b img=%0d flt=%0d expected 1 %0d %0d", n, st0, im0, fl0, exp_img[n], n + 1);
      end
      tick();
    end
    for (int c = 0; c < 40 && by0 === 1'b1; c++) tick();
    checks++;
    if (by0 !== 1'b0) begin errors++; $display("FAIL b2b_timeout busy=%b expected 0", by0); end
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    go0 = 1'b1; tick(); go0 = 1'b0;
    repeat (5) tick();
    checks++;
    if (im0 !== DW'(4) || fl0 !== DW'(3)) begin
      errors++;
      $display("FAIL abort_pre got img=%0d flt=%0d expected 4 3", im0, fl0);
    end
    #2 rst0 = 1'b1;
    #1;
    checks++;
    if (st0 !== 1'b0 || im0 !== '0 || fl0 !== '0 || by0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_async got st=%b img=%0d flt=%0d busy=%b expected 0 0 0 0", st0, im0, fl0, by0);
    end
    tick();
    rst0 = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (dn0 === 1'b1 || re0 === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b expected 0", saw_done); end
    go0 = 1'b1; tick(); go0 = 1'b0;
    checks++;
    if (st0 !== 1'b1 || im0 !== '0 || fl0 !== '0) begin
      errors++;
      $display("FAIL post_reset_go got st=%b img=%0d flt=%0d expected 1 0 0", st0, im0, fl0);
    end
    for (int c = 0; c < 40 && by0 === 1'b1; c++) tick();
    checks++;
    if (by0 !== 1'b0) begin errors++; $display("FAIL post_reset_timeout busy=%b expected 0", by0); end
    fill0();
    go0 = 1'b1; tick(); go0 = 1'b0;
    for (int n = 0; n < 15; n++) begin
      checks++;
      if (st0 !== 1'b1 || im0 !== DW'(exp_img[n]) || fl0 !== DW'(n % 3 + 1)) begin
        errors++;
        $display("FAIL reload_stream[%0d] got st=%b img=%0d flt=%0d expected 1 %0d %0d", n, st0, im0, fl0, exp_img[n], n % 3 + 1);
      end
      tick();
    end
    for (int c = 0; c < 40 && by0 === 1'b1; c++) tick();
    checks++;
    if (by0 !== 1'b0) begin errors++; $display("FAIL reload_timeout busy=%b expected 0", by0); end
  endtask

  task automatic test_addr_bound();
    load0(1'b1, 1'b0, 7, 15);
    load0(1'b0, 1'b1, 3, 15);
    go0 = 1'b1; tick(); go0 = 1'b0;
    for (int n = 0; n < 15; n++) begin
      checks++;
      if (st0 !== 1'b1 || im0 !== DW'(exp_img[n]) || fl0 !== DW'(n % 3 + 1)) begin
        errors++;
        $display("FAIL bound_stream[%0d] got st=%b img=%0d flt=%0d expected 1 %0d %0d", n, st0, im0, fl0, exp_img[n], n % 3 + 1);
      end
      tick();
    end
    checks++;
    if (st0 !== 1'b0 || by0 !== 1'b1) begin
      errors++;
      $display("FAIL bound_flush got st=%b busy=%b expected 0 1", st0, by0);
    end
    for (int c = 0; c < 40 && by0 === 1'b1; c++) tick();
    checks++;
    if (by0 !== 1'b0) begin errors++; $display("FAIL bound_timeout busy=%b expected 0", by0); end
  endtask

  task automatic test_k_eq_len();
    for (int i = 0; i < 3; i++) load1(1'b1, 1'b1, i, exp_k3[i]);
    for (int i = 0; i < 3; i++) load1(1'b0, 1'b1, i, 1);
    go1 = 1'b1; tick(); go1 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (st1 !== 1'b1 || im1 !== DW'(exp_k3[n]) || fl1 !== DW'(1)) begin
        errors++;
        $display("FAIL k3_stream[%0d] got st=%b img=%0d flt=%0d expected 1 %0d 1", n, st1, im1, fl1, exp_k3[n]);
      end
      tick();
    end
    checks++;
    if ({st1, im1, fl1, re1} !== '0 || by1 !== 1'b1) begin
      errors++;
      $display("FAIL k3_flush got st=%b img=%0d flt=%0d re=%b busy=%b expected 0 0 0 0 1", st1, im1, fl1, re1, by1);
    end
    for (int r = 1; r <= 7; r++) begin
      tick();
      checks++;
      if (re1 !== 1'b1 || dn1 !== (r == 7)) begin
        errors++;
        $display("FAIL k3_read[%0d] got re=%b done=%b expected 1 %b", r, re1, dn1, r == 7);
      end
    end
    tick();
    checks++;
    if (by1 !== 1'b0 || re1 !== 1'b0) begin
      errors++;
      $display("FAIL k3_end got busy=%b re=%b expected 0 0", by1, re1);
    end
  endtask

  initial begin
    li0 = 1'b0; lf0 = 1'b0; go0 = 1'b0; la0 = '0; ld0 = '0; rst0 = 1'b1;
    li1 = 1'b0; lf1 = 1'b0; go1 = 1'b0; la1 = '0; ld1 = '0; rst1 = 1'b1;
    test_reset();
    test_stream();
    test_ignore_during_stream();
    test_back_to_back();
    test_reset_abort();
    test_addr_bound();
    test_k_eq_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 Parameter: DATA_W, 4, width of image and filter samples.
REQ-002 Parameter: IMG_LEN, 7, image samples held in the buffer; legal range 3..15.
REQ-003 Parameter: K, 3, filter taps; legal range 1..IMG_LEN.
REQ-004 Parameter: READ_LEN, 7, cycles ReadEn is held after streaming.
REQ-005 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-high; clears all state.
REQ-007 Port: LoadImg  in  1  write LoadData into image buffer entry LoadAddr.
REQ-008 Port: LoadFlt  in  1  write LoadData into filter tap entry LoadAddr.
REQ-009 Port: LoadAddr  in  4  buffer or tap index.
REQ-010 Port: LoadData  in  DATA_W  sample to write.
REQ-011 Port: Go  in  1  one-cycle request to begin streaming.
REQ-012 Port: Start  out  1  downstream convolution-valid strobe, held high for the whole stream.
REQ-013 Port: Image  out  DATA_W  current image sample to the conv layer.
REQ-014 Port: Filter  out  DATA_W  current filter tap to the conv layer.
REQ-015 Port: ReadEn  out  1  downstream result read enable.
REQ-016 Port: Busy  out  1  high in every state except IDLE.
REQ-017 Port: Done  out  1  one-cycle pulse on the final ReadEn cycle.

Function
REQ-018 The FSM SHALL have states IDLE, STREAM, FLUSH and READ.
REQ-019 All outputs SHALL be registered.
REQ-020 In IDLE, the block SHALL drive Start, Image, Filter, ReadEn and Done to 0.
REQ-021 Loads SHALL be accepted only in IDLE; loads in any other state, and loads with LoadAddr >= IMG_LEN (image) or >= K (filter), SHALL be ignored.
REQ-022 If LoadImg and LoadFlt are both high in the same cycle, both writes SHALL occur.
REQ-023 Go sampled high in IDLE SHALL enter STREAM; on the first STREAM cycle (the cycle after Go), Start SHALL be 1, Image SHALL be img[0] and Filter SHALL be flt[0].
REQ-024 Go in any other state SHALL be ignored.
REQ-025 STREAM SHALL last NW*K cycles, where NW = IMG_LEN-K+1.
REQ-026 On STREAM cycle n (0-based), with w = n div K and t = n mod K, the block SHALL drive Image = img[w+t] and Filter = flt[t].
REQ-027 Sequencing SHALL use a tap counter (0..K-1) and a window counter (0..NW-1); the window counter SHALL advance when the tap counter wraps from K-1 to 0.
REQ-028 After the last STREAM cycle, FLUSH SHALL run for exactly 1 cycle with Start=0, Image=0 and Filter=0.
REQ-029 READ SHALL follow FLUSH, with ReadEn=1 for READ_LEN cycles.
REQ-030 Done SHALL be 1 on the last READ cycle only; the next state SHALL be IDLE.
REQ-031 Go sampled on the same edge that returns the FSM to IDLE SHALL be ignored.
REQ-032 Buffer contents SHALL persist across runs, so a second Go replays identical data.
REQ-033 If K = IMG_LEN, the block SHALL stream exactly 1 window of K cycles.

Reset
REQ-034 Reset SHALL asynchronously force IDLE, clear both counters, and drive all outputs to 0.
REQ-035 Reset SHALL clear the image and filter buffers to 0.
REQ-036 Reset asserted mid-STREAM or mid-READ SHALL abort the run immediately, with no Done pulse.
REQ-037 After reset deasserts, the first Go SHALL be honoured.

Structure
REQ-038 A shared package SHALL hold DATA_W, IMG_LEN, K, READ_LEN, the NW derivation and the FSM state enum.
REQ-039 The block SHALL instantiate one sub-module, window_index_gen, which owns the tap and window counters and outputs the image index w+t, the tap index t, and a last flag.

Verification
REQ-040 Scenario: load img=1..7 and flt=1,2,3, then Go -> 15 Start cycles with Image sequence 1,2,3,2,3,4,3,4,5,4,5,6,5,6,7 and Filter repeating 1,2,3.
REQ-041 Scenario: continuing the previous run -> 1 FLUSH cycle with all outputs 0, then ReadEn high for 7 cycles, Done high on the 7th, Busy low on the next cycle.
REQ-042 Scenario: assert Go and LoadImg(addr 0, data 9) during STREAM -> stream unchanged; a second run still starts with Image=1.
REQ-043 Scenario: assert reset at STREAM cycle 5 -> Start, Image and Filter are 0 immediately, no Done; a following load and Go produces the full 15-cycle sequence.
REQ-044 Scenario: LoadImg with LoadAddr=7 while IMG_LEN=7 -> buffer unchanged.
REQ-045 Scenario: set K=IMG_LEN=3 with img=4,5,6 and flt=1,1,1 -> 3 Start cycles with Image 4,5,6, then FLUSH, then READ.
